// File: rtl/qar_mem_pkg.sv
// Shared types and helpers for the qar_core external data-memory target.
package qar_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam logic [31:0] QAR_ERR_RDATA = 32'hDEAD_BEEF;
    localparam logic [15:0] QAR_LFSR_TAPS = 16'hB400;

    // Misaligned, or any address bit above the word index is set.
    function automatic logic dmem_addr_err(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/qar_lfsr16.sv
// 16-bit Galois LFSR (right-shifting, taps QAR_LFSR_TAPS) used to randomise wait states.
module qar_lfsr16
    import qar_mem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEED;
        else if (en)
            state <= {1'b0, state[15:1]} ^ (state[0] ? QAR_LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/qar_dmem_responder.sv
// Data-memory target for the qar_core bus: one request at a time, programmable wait states,
// single-cycle mem_ready. Define QAR_DMEM_RAND_WAIT_EN to draw wait states (0..3) from an LFSR.
module qar_dmem_responder
    import qar_mem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          AW        = $clog2(DEPTH),
    parameter string       INIT_FILE = "",
    parameter logic [31:0] ERR_RDATA = QAR_ERR_RDATA,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic [3:0]  cfg_wait,
    output logic        err_sticky,
    output logic [15:0] access_cnt
);

    logic [31:0] mem [DEPTH];

    dmem_state_t   state, state_nx;
    dmem_req_t     req;
    logic [3:0]    cnt;
    logic [3:0]    cnt_load;
    logic          capture, fire;
    logic          req_err;
    logic [AW-1:0] idx;

    assign req_err = dmem_addr_err(req.addr, AW);
    assign idx     = req.addr[AW+1:2];

`ifdef QAR_DMEM_RAND_WAIT_EN
    logic [15:0] lfsr;

    qar_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .state (lfsr)
    );

    assign cnt_load = {2'b00, lfsr[1:0]};
`else
    assign cnt_load = cfg_wait;
`endif

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        fire     = 1'b0;
        case (state)
            IDLE: if (mem_valid) begin
                capture  = 1'b1;
                state_nx = BUSY;
            end
            BUSY: if (cnt == 4'd0) begin
                fire     = 1'b1;
                state_nx = DONE;
            end
            // Turnaround cycle: a still-held mem_valid must not re-capture.
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req        <= '0;
            cnt        <= 4'd0;
            mem_ready  <= 1'b0;
            mem_rdata  <= 32'd0;
            err_sticky <= 1'b0;
            access_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            mem_ready <= fire;
            if (capture) begin
                req <= '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
                cnt <= cnt_load;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                access_cnt <= access_cnt + 16'd1;
                if (req_err)
                    err_sticky <= 1'b1;
                if (!req.we)
                    mem_rdata <= req_err ? ERR_RDATA : mem[idx];
            end
        end
    end

    // Array has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (fire && req.we && !req_err)
            mem[idx] <= req.wdata;
    end

endmodule

// File: tb/tb_qar_dmem_responder.sv
// Directed bench for qar_dmem_responder with a read-data scoreboard and a shadow memory model.
module tb_qar_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  cfg_wait;
    logic        err_sticky;
    logic [15:0] access_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] shadow [256];
    logic [31:0] exp_q [$];
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    qar_dmem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .cfg_wait   (cfg_wait),
        .err_sticky (err_sticky),
        .access_cnt (access_cnt)
    );

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h400);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; lat = cycles from valid first driven to the ready cycle.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int exp_lat, input bit poke_cfg, output int lat);
        logic got;
        logic [31:0] exp;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        if (!we)
            exp_q.push_back(is_err(addr) ? 32'hDEAD_BEEF : shadow[addr[9:2]]);
        else if (!is_err(addr))
            shadow[addr[9:2]] = wdata;
        @(posedge clk);
        #1;
        if (poke_cfg) cfg_wait = 4'd15;
        mem_addr  = 32'hFFFF_FFFF;
        mem_wdata = 32'h0BAD_0BAD;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_ready) got = 1'b1;
        end
        mem_valid = 1'b0;
        exp_cnt++;
        check("ready_seen", {31'd0, got}, 32'd1);
        if (exp_lat >= 0)
            check("latency", lat, exp_lat);
        if (!we && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("rdata", mem_rdata, exp);
        end
        @(posedge clk);
        #1;
        check("ready_pulse_1cyc", {31'd0, mem_ready}, 32'd0);
    endtask

    int lat, gap;
    logic got2;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
        exp_cnt   = 16'd0;
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        cfg_wait  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_err", {31'd0, err_sticky}, 32'd0);
        check("rst_cnt", {16'd0, access_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef QAR_DMEM_RAND_WAIT_EN
        // Zero wait states.
        do_access(1'b1, 32'h40, 32'h1234_5678, 2, 1'b0, lat);
        do_access(1'b0, 32'h40, 32'h0, 2, 1'b0, lat);
        check("cnt_after_2", {16'd0, access_cnt}, 32'd2);

        // Three wait states; cfg_wait bumped mid-flight on the read must be ignored.
        cfg_wait = 4'd3;
        do_access(1'b1, 32'h0, 32'hCAFE_F00D, 5, 1'b0, lat);
        cfg_wait = 4'd3;
        do_access(1'b0, 32'h0, 32'h0, 5, 1'b1, lat);
        cfg_wait = 4'd0;
        check("err_still_clear", {31'd0, err_sticky}, 32'd0);

        // Out-of-range read, then misaligned write aliasing word 0.
        do_access(1'b0, 32'h400, 32'h0, 2, 1'b0, lat);
        check("err_set", {31'd0, err_sticky}, 32'd1);
        do_access(1'b1, 32'h402, 32'h5555_AAAA, 2, 1'b0, lat);
        check("err_held", {31'd0, err_sticky}, 32'd1);
        do_access(1'b0, 32'h0, 32'h0, 2, 1'b0, lat);
        check("cnt_after_err", {16'd0, access_cnt}, {16'd0, exp_cnt});

        // Valid held through ready: next capture only after DONE, period W+3 = 3.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 32'h40;
        got2 = 1'b0;
        for (int i = 0; i < 20 && !got2; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) got2 = 1'b1;
        end
        check("hold_first_ready", {31'd0, got2}, 32'd1);
        check("hold_rdata", mem_rdata, 32'h1234_5678);
        check("hold_cnt1", {16'd0, access_cnt}, {16'd0, exp_cnt + 16'd1});
        gap = 0;
        got2 = 1'b0;
        for (int i = 0; i < 20 && !got2; i++) begin
            @(posedge clk);
            #1;
            gap++;
            if (mem_ready) got2 = 1'b1;
        end
        mem_valid = 1'b0;
        check("hold_gap", gap, 3);
        exp_cnt = exp_cnt + 16'd2;
        repeat (6) @(posedge clk);
        #1;
        check("hold_cnt2", {16'd0, access_cnt}, {16'd0, exp_cnt});

        // Reset in the middle of a 5-wait write.
        do_access(1'b1, 32'h10, 32'h1111_2222, -1, 1'b0, lat);
        cfg_wait = 4'd5;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h10;
        mem_wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        got2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) got2 = 1'b1;
        end
        check("rst_mid_no_ready", {31'd0, got2}, 32'd0);
        check("rst_mid_cnt", {16'd0, access_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt  = 16'd0;
        cfg_wait = 4'd0;
        do_access(1'b0, 32'h10, 32'h0, 2, 1'b0, lat);
        check("rst_mid_cnt_after", {16'd0, access_cnt}, 32'd1);
`else
        // LFSR-driven wait states; cfg_wait set high to show it is ignored.
        cfg_wait = 4'd9;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            do_access(1'($urandom_range(0, 1)), a, $urandom, -1, 1'b0, lat);
            check("rand_lat_range", {31'd0, (lat >= 2 && lat <= 5)}, 32'd1);
        end
        check("rand_cnt", {16'd0, access_cnt}, {16'd0, exp_cnt});
        check("rand_err", {31'd0, err_sticky}, 32'd0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
